s2mm_cmd_queue: RTL
===================

S2MM_CMD_QUEUE -- requirements
Module: s2mm_cmd_queue

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, address width; NUM_CH, 2, request channels (1..8); FIFO_DEPTH, 4, command FIFO entries (power of 2); MAX_OUTSTANDING, 8, maximum commands queued plus in flight (1..15).
REQ-002 SHALL use clock clk; reset rstn, synchronous, active-low.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  NUM_CH  per-channel write request
- req_ready  out  NUM_CH  per-channel accept
- req_addr  in  NUM_CH*ADDR_WIDTH  start address; channel i at slice i
- req_btt  in  NUM_CH*23  bytes to transfer
- req_eof  in  NUM_CH  EOF flag
- m_axis_s2mm_cmd_tvalid  out  1  command valid
- m_axis_s2mm_cmd_tready  in  1  command ready
- m_axis_s2mm_cmd_tdata  out  ADDR_WIDTH+40  datamover command
- s_axis_s2mm_sts_tvalid  in  1  status valid
- s_axis_s2mm_sts_tready  out  1  status ready
- s_axis_s2mm_sts_tdata  in  8  status byte
- outstanding  out  4  commands issued, status not yet returned
- err  out  1  sticky error
- btt_zero  out  1  one-cycle pulse on dropped zero-length request

Function
REQ-004 Command layout SHALL be: [AW+39:AW+36]=0; [AW+35:AW+32]=tag; [AW+31:32]=addr; [31]=0 (DRE realign); [30]=eof; [29:24]=0; [23]=1 (INCR); [22:0]=btt.
REQ-005 Tag SHALL be a 4-bit counter, reset 0, incremented per FIFO push, wrapping 15->0.
REQ-006 Arbiter SHALL be round-robin: at most one grant per cycle; the search starts at the channel after the last granted one; pointer resets to channel 0.
REQ-007 req_ready[i] SHALL be combinational, high only for the granted channel; a grant requires FIFO not full and credit available (REQ-010).
REQ-008 No push SHALL occur while the FIFO is full, even with a simultaneous pop.
REQ-009 A granted request with btt==0 SHALL be accepted, not pushed, not given a tag, and SHALL pulse btt_zero for 1 cycle.
REQ-010 Credit SHALL exist when fifo_count + outstanding < MAX_OUTSTANDING.
REQ-011 tvalid SHALL equal FIFO not-empty; tdata SHALL hold the head entry and stay stable while tvalid && !tready; pop on tvalid && tready.
REQ-012 Latency SHALL be 1 cycle from an accepted request to tvalid when the FIFO is empty.
REQ-013 outstanding SHALL increment on a command handshake and decrement on a status handshake; both together SHALL leave it unchanged; it SHALL saturate at 0 and 15.
REQ-014 Status byte decode SHALL be: [7]=OKAY, [6]=SLVERR, [5]=DECERR, [4]=INTERR, [3:0]=tag.
REQ-015 err SHALL set on a status handshake with OKAY=0, any of [6:4]=1, or a tag not equal to the expected in-order tag (counter, reset 0, +1 per status); err SHALL also set on a status handshake while outstanding==0.

Reset
REQ-016 On rstn=0 at a clock edge: FIFO empty, tvalid=0, tdata=0, req_ready=0, outstanding=0, err=0, btt_zero=0, tag and expected tag=0, arbiter pointer=0.
REQ-017 Reset mid-operation SHALL discard queued and in-flight commands with no further handshakes.

Configuration
REQ-018 Macro S2MM_CMD_STS_TRACK_EN: defined -> REQ-013/015 active, s_axis_s2mm_sts_tready=1; undefined -> status port ignored, sts_tready=1, outstanding=0, err=0, credit = FIFO not full only.

Structure
REQ-019 Package s2mm_cmd_pkg SHALL hold command field offsets, TAG_W=4, BTT_W=23, TYPE_INCR, and status bit positions.
REQ-020 Sub-module s2mm_cmd_fifo SHALL be a synchronous FIFO (registered head, count output) instantiated once.

Verification
REQ-021 Ch0 addr 0x1000_0000, btt 128, eof 1, tready=1 -> next cycle tvalid=1, tdata tag 0, addr 0x1000_0000, bit30=1, bit23=1, btt 128.
REQ-022 Both channels valid continuously, tready=1 -> grants alternate 0,1,0,1; tags 0,1,2,3.
REQ-023 tready=0, FIFO_DEPTH=4 -> after 4 accepts req_ready=0; tdata unchanged; after tready=1 for 1 cycle, exactly one more accept.
REQ-024 MAX_OUTSTANDING=2, no status returned -> after 2 accepts no grant; status 0x80 -> outstanding=1, one grant follows.
REQ-025 Request with btt 0 -> req_ready=1, btt_zero pulse, no tvalid, next tag unchanged.
REQ-026 Status 0xC0 or tag mismatch (0x81 when 0 expected) -> err=1 and held until reset.

Source files
------------

// File: rtl/s2mm_cmd_pkg.sv
// s2mm_cmd_pkg: shared constants for the S2MM datamover command queue.
//   - Command word field offsets (low 32 bits fixed, address and tag above)
//   - Tag / byte-count widths and the INCR burst type encoding
//   - Status byte bit positions
package s2mm_cmd_pkg;

   localparam int TAG_W      = 4;
   localparam int BTT_W      = 23;
   localparam int STS_W      = 8;
   localparam int OUTST_W    = 4;
   localparam int CMD_HI_W   = 40;   // command width beyond the address field

   // Command word layout (address sits at CMD_ADDR_LSB, tag directly above it)
   localparam int CMD_BTT_LSB  = 0;
   localparam int CMD_TYPE_BIT = 23;
   localparam int CMD_EOF_BIT  = 30;
   localparam int CMD_DRE_BIT  = 31;
   localparam int CMD_ADDR_LSB = 32;

   localparam logic TYPE_INCR = 1'b1;

   // Status byte layout
   localparam int STS_OKAY_BIT   = 7;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_INTERR_BIT = 4;
   localparam int STS_TAG_LSB    = 0;

endpackage

// File: rtl/s2mm_cmd_fifo.sv
// s2mm_cmd_fifo: synchronous first-word-fall-through FIFO with a registered
// head output.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   push, din        write strobe / data (ignored while full)
//   pop              read strobe (ignored while empty)
//   head             registered head entry, zero when empty
//   empty, full      status flags
//   count            number of stored entries
module s2mm_cmd_fifo
   import s2mm_cmd_pkg::*;
#(
   parameter int WIDTH = 72,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_after_pop;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_next;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = cnt;
   assign head    = head_q;

   assign rd_next       = rd_ptr + PTR_W'(do_pop);
   assign cnt_after_pop = cnt - CNT_W'(do_pop);

   // The head register follows the entry at the post-pop read pointer. When
   // that leaves nothing stored, an incoming write becomes the new head
   // directly, which gives one-cycle push-to-valid latency on an empty FIFO.
   always_comb begin
      head_next = '0;
      if (cnt_after_pop != '0) begin
         head_next = mem[rd_next];
      end else if (do_push) begin
         head_next = din;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head_q <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(do_push);
         rd_ptr <= rd_next;
         cnt    <= cnt_after_pop + CNT_W'(do_push);
         head_q <= head_next;
      end
   end

endmodule

// File: rtl/s2mm_cmd_queue.sv
// s2mm_cmd_queue: round-robin arbiter that packs per-channel write requests
// into AXI datamover S2MM commands, queues them and tracks returned status.
// Build option: define S2MM_CMD_STS_TRACK_EN to enable outstanding-command
// counting, credit limiting and status error checking; without it the status
// port is ignored, outstanding/err read 0 and credit is just "FIFO not full".
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   req_valid/ready              per-channel request handshake (ready is
//                                combinational, one-hot on the granted channel)
//   req_addr/btt/eof             per-channel command fields, channel i at slice i
//   m_axis_s2mm_cmd_*            command stream out (ADDR_WIDTH+40 bits)
//   s_axis_s2mm_sts_*            status stream in (8 bits, always ready)
//   outstanding                  commands issued without returned status
//   err                          sticky status error
//   btt_zero                     one-cycle pulse when a zero-length request is dropped
module s2mm_cmd_queue
   import s2mm_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int NUM_CH          = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH-1:0]            req_valid,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CH*BTT_W-1:0]      req_btt,
   input  logic [NUM_CH-1:0]            req_eof,
   output logic                         m_axis_s2mm_cmd_tvalid,
   input  logic                         m_axis_s2mm_cmd_tready,
   output logic [ADDR_WIDTH+39:0]       m_axis_s2mm_cmd_tdata,
   input  logic                         s_axis_s2mm_sts_tvalid,
   output logic                         s_axis_s2mm_sts_tready,
   input  logic [STS_W-1:0]             s_axis_s2mm_sts_tdata,
   output logic [OUTST_W-1:0]           outstanding,
   output logic                         err,
   output logic                         btt_zero
);

   localparam int CMD_W  = ADDR_WIDTH + CMD_HI_W;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   function automatic logic [CMD_W-1:0] build_cmd(
      input logic [TAG_W-1:0]      tag,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  eof,
      input logic [BTT_W-1:0]      btt
   );
      logic [CMD_W-1:0] c;
      c = '0;
      c[CMD_BTT_LSB +: BTT_W]                = btt;
      c[CMD_TYPE_BIT]                        = TYPE_INCR;
      c[CMD_EOF_BIT]                         = eof;
      c[CMD_DRE_BIT]                         = 1'b0;
      c[CMD_ADDR_LSB +: ADDR_WIDTH]          = addr;
      c[CMD_ADDR_LSB + ADDR_WIDTH +: TAG_W]  = tag;
      return c;
   endfunction

   logic [CH_W-1:0]       rr_ptr;
   logic [CH_W-1:0]       grant_idx;
   logic                  grant_any;
   logic                  credit;
   logic                  accept;
   logic                  zero_len;
   logic                  push;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BTT_W-1:0]      sel_btt;
   logic                  sel_eof;
   logic [TAG_W-1:0]      tag;
   logic [CMD_W-1:0]      cmd_din;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [FCNT_W-1:0]     fifo_count;
   logic                  cmd_hs;
   logic                  btt_zero_q;

   // Round-robin search starting at rr_ptr (the channel after the last grant)
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = rr_ptr;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = CH_W'(idx);
         end
      end
   end

   // rstn gating keeps the request side silent while reset is held
   assign accept = rstn && grant_any && !fifo_full && credit;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign sel_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_btt  = req_btt[grant_idx*BTT_W +: BTT_W];
   assign sel_eof  = req_eof[grant_idx];
   assign zero_len = (sel_btt == '0);
   assign push     = accept && !zero_len;
   assign cmd_din  = build_cmd(tag, sel_addr, sel_eof, sel_btt);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr     <= '0;
         tag        <= '0;
         btt_zero_q <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
         end
         if (push) begin
            tag <= tag + 1'b1;
         end
         btt_zero_q <= accept && zero_len;
      end
   end

   assign btt_zero = btt_zero_q;

   s2mm_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (cmd_din),
      .pop   (cmd_hs),
      .head  (m_axis_s2mm_cmd_tdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign m_axis_s2mm_cmd_tvalid = !fifo_empty;
   assign cmd_hs                 = m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready;
   assign s_axis_s2mm_sts_tready = 1'b1;

`ifdef S2MM_CMD_STS_TRACK_EN

   function automatic logic sts_bad(
      input logic [STS_W-1:0]   sts,
      input logic [TAG_W-1:0]   exp_tag,
      input logic [OUTST_W-1:0] cnt
   );
      return !sts[STS_OKAY_BIT] || sts[STS_SLVERR_BIT] || sts[STS_DECERR_BIT] ||
             sts[STS_INTERR_BIT] || (sts[STS_TAG_LSB +: TAG_W] != exp_tag) ||
             (cnt == '0);
   endfunction

   logic               sts_hs;
   logic [OUTST_W-1:0] outst;
   logic [TAG_W-1:0]   exp_tag;
   logic               err_q;

   assign sts_hs = s_axis_s2mm_sts_tvalid;   // status is always accepted
   assign credit = (int'(fifo_count) + int'(outst)) < MAX_OUTSTANDING;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         outst   <= '0;
         exp_tag <= '0;
         err_q   <= 1'b0;
      end else begin
         case ({cmd_hs, sts_hs})
            2'b10:   if (outst != '1) outst <= outst + 1'b1;
            2'b01:   if (outst != '0) outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
         if (sts_hs) begin
            exp_tag <= exp_tag + 1'b1;
            if (sts_bad(s_axis_s2mm_sts_tdata, exp_tag, outst)) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign outstanding = outst;
   assign err         = err_q;

`else

   logic unused_sts;
   assign unused_sts  = ^{s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tdata, fifo_count};
   assign credit      = 1'b1;
   assign outstanding = '0;
   assign err         = 1'b0;

`endif

endmodule
